// File: rtl/rip_axi_pkg.sv
// -----------------------------------------------------------------------------
// rip_axi_pkg
//   Shared AXI constants and FSM state types for the rip_axi_slave_mem slice.
//   Contents:
//     AXI_BURST_FIXED/INCR/WRAP  - AxBURST encodings
//     AXI_RESP_OKAY/SLVERR       - xRESP encodings
//     w_state_e / r_state_e      - write / read FSM states
//     burst_advances()           - true when the beat address steps per beat
// -----------------------------------------------------------------------------
package rip_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

  // WRAP and the reserved encoding step like INCR; only FIXED holds the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst != AXI_BURST_FIXED);
  endfunction

endpackage

// File: rtl/rip_axi_interface.sv
// -----------------------------------------------------------------------------
// rip_axi_interface
//   AXI4 signal bundle (AW, W, B, AR, R channels) with master and slave
//   modports.
//   Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH.
// -----------------------------------------------------------------------------
interface rip_axi_interface #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/rip_axi_slave_ram.sv
// -----------------------------------------------------------------------------
// rip_axi_slave_ram
//   Word-addressed storage: one write port with byte enables, one synchronous
//   read port with 1-cycle latency. A read and write of the same word in the
//   same cycle returns the old contents. Contents are never reset; only the
//   read data register is.
//   Ports:
//     clk_i    - clock
//     rst_ni   - async active-low reset (read data register only)
//     we_i     - write enable
//     waddr_i  - write word index
//     wstrb_i  - byte lane enables
//     wdata_i  - write data
//     re_i     - read enable
//     raddr_i  - read word index
//     rdata_o  - registered read data
// -----------------------------------------------------------------------------
module rip_axi_slave_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rip_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// rip_axi_slave_mem
//   AXI4 memory responder with independent write (W_IDLE/W_DATA/W_RESP) and
//   read (R_IDLE/R_FETCH/R_DATA) FSMs over a 1W/1R synchronous RAM.
//   Ports:
//     clk  - clock, rising edge
//     rstn - async active-low reset
//     axi  - rip_axi_interface.slave responder port
//   Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH (32/64), MEM_WORDS (pow2).
//   Build option RIP_AXI_SLAVE_ERR_EN: out-of-range addresses and WRAP/reserved
//   bursts drop writes, read as zero and answer SLVERR. Without it addresses
//   wrap modulo the memory size and WRAP/reserved behave as INCR.
// -----------------------------------------------------------------------------
module rip_axi_slave_mem
  import rip_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  rip_axi_interface.slave axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned B      = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (!burst_advances(burst)) return a;
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic [1:0]            b_resp_q, b_resp_d;

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;

  logic                  w_beat_err, r_beat_err;
  logic                  w_last_beat, r_last_beat;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef RIP_AXI_SLAVE_ERR_EN
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(STRB_W);

  function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [1:0]            burst);
    return (64'(a) >= MEM_BYTES) ||
           !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
  endfunction

  assign w_beat_err = beat_err(aw_addr_q, aw_burst_q);
  assign r_beat_err = beat_err(ar_addr_q, ar_burst_q);
`else
  assign w_beat_err = 1'b0;
  assign r_beat_err = 1'b0;
`endif

  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign r_last_beat = (r_cnt_q == ar_len_q);

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= AXI_BURST_FIXED;
      w_cnt_q    <= '0;
      b_resp_q   <= AXI_RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      b_resp_q   <= b_resp_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    b_resp_d   = b_resp_q;
    ram_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (axi.awvalid) begin
          aw_id_d    = axi.awid;
          aw_addr_d  = axi.awaddr;
          aw_len_d   = axi.awlen;
          aw_size_d  = axi.awsize;
          aw_burst_d = axi.awburst;
          w_cnt_d    = '0;
          b_resp_d   = AXI_RESP_OKAY;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid) begin
          ram_we = !w_beat_err;
          // Termination follows AWLEN; WLAST only grades the response.
          if (w_beat_err || (axi.wlast != w_last_beat)) begin
            b_resp_d = AXI_RESP_SLVERR;
          end
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_cnt_q + 8'd1;
            aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
          end
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign axi.awready = (w_state_q == W_IDLE);
  assign axi.wready  = (w_state_q == W_DATA);
  assign axi.bvalid  = (w_state_q == W_RESP);
  assign axi.bid     = aw_id_q;
  assign axi.bresp   = b_resp_q;

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= AXI_BURST_FIXED;
      r_cnt_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (axi.arvalid) begin
          ar_id_d    = axi.arid;
          ar_addr_d  = axi.araddr;
          ar_len_d   = axi.arlen;
          ar_size_d  = axi.arsize;
          ar_burst_d = axi.arburst;
          r_cnt_d    = '0;
          r_state_d  = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (axi.rready) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ram_re = (r_state_q == R_FETCH);

  assign axi.arready = (r_state_q == R_IDLE);
  assign axi.rvalid  = (r_state_q == R_DATA);
  assign axi.rlast   = (r_state_q == R_DATA) && r_last_beat;
  assign axi.rid     = ar_id_q;
  // RAM output register only loads in R_FETCH, so RDATA holds while stalled.
  assign axi.rdata   = r_beat_err ? '0 : ram_rdata;
  assign axi.rresp   = r_beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // ------------------------------------------------------------------ storage
  rip_axi_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .we_i    (ram_we),
    .waddr_i (aw_addr_q[IDX_W+B-1:B]),
    .wstrb_i (axi.wstrb),
    .wdata_i (axi.wdata),
    .re_i    (ram_re),
    .raddr_i (ar_addr_q[IDX_W+B-1:B]),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_rip_axi_slave_mem.sv
module tb_rip_axi_slave_mem;
  import rip_axi_pkg::*;

  localparam int unsigned IDW = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rip_axi_interface #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  rip_axi_slave_mem #(
    .ID_WIDTH   (IDW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_WORDS  (MW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .axi  (axi_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] wbuf    [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  int unsigned rd_lat  [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    bit hs;
    axi_if.awvalid = 1'b1; axi_if.awaddr = addr; axi_if.awlen = len;
    axi_if.awsize  = 3'd2; axi_if.awburst = burst; axi_if.awid = id;
    for (int i = 0; i < 20; i++) begin
      hs = axi_if.awready;
      tick();
      if (hs) begin
        axi_if.awvalid = 1'b0;
        return;
      end
    end
    axi_if.awvalid = 1'b0;
    chk("aw_timeout", 1, 0);
  endtask

  task automatic w_send(input int unsigned nbeats, input logic [3:0] strb, input bit bad_last);
    bit done;
    for (int b = 0; b < int'(nbeats); b++) begin
      done = 1'b0;
      axi_if.wvalid = 1'b1; axi_if.wdata = wbuf[b]; axi_if.wstrb = strb;
      axi_if.wlast  = (b == int'(nbeats) - 1) && !bad_last;
      for (int i = 0; i < 20 && !done; i++) begin
        done = axi_if.wready;
        tick();
      end
      if (!done) chk("w_timeout", 1, 0);
    end
    axi_if.wvalid = 1'b0;
    axi_if.wlast  = 1'b0;
  endtask

  task automatic b_recv(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
    bit done;
    done = 1'b0;
    axi_if.bready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi_if.bvalid) begin
        chk({tag, "_bresp"}, axi_if.bresp, exp_resp);
        chk({tag, "_bid"}, axi_if.bid, exp_id);
        done = 1'b1;
      end
      tick();
    end
    axi_if.bready = 1'b0;
    if (!done) chk({tag, "_b_timeout"}, 1, 0);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    bit hs;
    axi_if.arvalid = 1'b1; axi_if.araddr = addr; axi_if.arlen = len;
    axi_if.arsize  = 3'd2; axi_if.arburst = burst; axi_if.arid = id;
    for (int i = 0; i < 20; i++) begin
      hs = axi_if.arready;
      tick();
      if (hs) begin
        axi_if.arvalid = 1'b0;
        return;
      end
    end
    axi_if.arvalid = 1'b0;
    chk("ar_timeout", 1, 0);
  endtask

  // Collects len+1 beats; rd_lat counts cycles from the preceding handshake.
  task automatic ar_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    int unsigned lat;
    ar_send(addr, len, burst, id);
    for (int b = 0; b <= int'(len); b++) begin
      lat = 1;
      while (!axi_if.rvalid && lat < 20) begin
        tick();
        lat++;
      end
      if (!axi_if.rvalid) begin
        chk("r_timeout", 1, 0);
        return;
      end
      rd_data[b] = axi_if.rdata; rd_last[b] = axi_if.rlast;
      rd_resp[b] = axi_if.rresp; rd_id[b]   = axi_if.rid;
      rd_lat[b]  = lat;
      axi_if.rready = 1'b1;
      tick();
      axi_if.rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    axi_if.awvalid = 0; axi_if.awid = 0; axi_if.awaddr = 0; axi_if.awlen = 0;
    axi_if.awsize = 0; axi_if.awburst = 0;
    axi_if.wvalid = 0; axi_if.wdata = 0; axi_if.wstrb = 0; axi_if.wlast = 0;
    axi_if.bready = 0;
    axi_if.arvalid = 0; axi_if.arid = 0; axi_if.araddr = 0; axi_if.arlen = 0;
    axi_if.arsize = 0; axi_if.arburst = 0;
    axi_if.rready = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", axi_if.awready, 1);
    chk("rst_arready", axi_if.arready, 1);
    chk("rst_wready",  axi_if.wready,  0);
    chk("rst_bvalid",  axi_if.bvalid,  0);
    chk("rst_rvalid",  axi_if.rvalid,  0);
    chk("rst_rlast",   axi_if.rlast,   0);
    chk("rst_bid",     axi_if.bid,     0);
    chk("rst_rid",     axi_if.rid,     0);
    chk("rst_bresp",   axi_if.bresp,   0);
    chk("rst_rresp",   axi_if.rresp,   0);
    chk("rst_rdata",   axi_if.rdata,   0);
    rstn = 1'b1;
    tick();

    // Single write / read
    wbuf[0] = 32'hDEADBEEF;
    aw_send(32'h10, 8'd0, AXI_BURST_INCR, 4'h1);
    w_send(1, 4'hF, 1'b0);
    b_recv("single", AXI_RESP_OKAY, 4'h1);
    ar_read(32'h10, 8'd0, AXI_BURST_INCR, 4'h2);
    chk("single_rdata", rd_data[0], 32'hDEADBEEF);
    chk("single_rlast", rd_last[0], 1);
    chk("single_rresp", rd_resp[0], AXI_RESP_OKAY);
    chk("single_rid",   rd_id[0],   4'h2);
    chk("single_lat",   rd_lat[0],  2);

    // INCR burst of 4
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    aw_send(32'h100, 8'd3, AXI_BURST_INCR, 4'h5);
    w_send(4, 4'hF, 1'b0);
    b_recv("incr", AXI_RESP_OKAY, 4'h5);
    ar_read(32'h100, 8'd3, AXI_BURST_INCR, 4'h5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rd_data[i], 32'(i + 1));
      chk($sformatf("incr_rlast%0d", i), rd_last[i], (i == 3) ? 1 : 0);
      chk($sformatf("incr_rid%0d", i),   rd_id[i],   4'h5);
      chk($sformatf("incr_lat%0d", i),   rd_lat[i],  2);
    end

    // Partial strobe overwrite
    wbuf[0] = 32'h11223344;
    aw_send(32'h20, 8'd0, AXI_BURST_INCR, 4'h3);
    w_send(1, 4'hF, 1'b0);
    b_recv("strb_init", AXI_RESP_OKAY, 4'h3);
    wbuf[0] = 32'hAABBCCDD;
    aw_send(32'h20, 8'd0, AXI_BURST_INCR, 4'h3);
    w_send(1, 4'b0101, 1'b0);
    b_recv("strb", AXI_RESP_OKAY, 4'h3);
    ar_read(32'h20, 8'd0, AXI_BURST_INCR, 4'h3);
    chk("strb_rdata", rd_data[0], 32'h11BB33DD);

    // FIXED burst: every beat lands on the same word, last one wins
    wbuf[0] = 32'h0A; wbuf[1] = 32'h0B; wbuf[2] = 32'h0C;
    aw_send(32'h40, 8'd2, AXI_BURST_FIXED, 4'h3);
    w_send(3, 4'hF, 1'b0);
    b_recv("fixed", AXI_RESP_OKAY, 4'h3);
    ar_read(32'h40, 8'd0, AXI_BURST_INCR, 4'h3);
    chk("fixed_rdata", rd_data[0], 32'h0C);

    // WLAST missing on the final beat
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    aw_send(32'h50, 8'd1, AXI_BURST_INCR, 4'h6);
    w_send(2, 4'hF, 1'b1);
    b_recv("wlast_err", AXI_RESP_SLVERR, 4'h6);

    // B backpressure
    wbuf[0] = 32'h600DF00D;
    aw_send(32'h60, 8'd0, AXI_BURST_INCR, 4'h9);
    w_send(1, 4'hF, 1'b0);
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h70; axi_if.awid = 4'hC;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bhold_bvalid%0d", k), axi_if.bvalid, 1);
      chk($sformatf("bhold_bid%0d", k), axi_if.bid, 4'h9);
      chk($sformatf("bhold_bresp%0d", k), axi_if.bresp, AXI_RESP_OKAY);
      chk($sformatf("bhold_awready%0d", k), axi_if.awready, 0);
      tick();
    end
    axi_if.awvalid = 1'b0;
    b_recv("bhold", AXI_RESP_OKAY, 4'h9);
    chk("bhold_after_bvalid", axi_if.bvalid, 0);

    // R backpressure
    ar_send(32'h60, 8'd0, AXI_BURST_INCR, 4'hA);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi_if.rvalid) done = 1'b1;
      else tick();
    end
    if (!done) chk("rhold_timeout", 1, 0);
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h10; axi_if.arid = 4'hB;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rhold_rvalid%0d", k), axi_if.rvalid, 1);
      chk($sformatf("rhold_rdata%0d", k), axi_if.rdata, 32'h600DF00D);
      chk($sformatf("rhold_rid%0d", k), axi_if.rid, 4'hA);
      chk($sformatf("rhold_rlast%0d", k), axi_if.rlast, 1);
      chk($sformatf("rhold_arready%0d", k), axi_if.arready, 0);
      tick();
    end
    axi_if.arvalid = 1'b0;
    axi_if.rready = 1'b1;
    tick();
    axi_if.rready = 1'b0;
    chk("rhold_after_rvalid", axi_if.rvalid, 0);
    chk("rhold_after_arready", axi_if.arready, 1);

    // Out-of-range read
    wbuf[0] = 32'hCAFEF00D;
    aw_send(32'h0, 8'd0, AXI_BURST_INCR, 4'h1);
    w_send(1, 4'hF, 1'b0);
    b_recv("word0", AXI_RESP_OKAY, 4'h1);
    ar_read(MW * 4, 8'd0, AXI_BURST_INCR, 4'h4);
`ifdef RIP_AXI_SLAVE_ERR_EN
    chk("oor_rresp", rd_resp[0], AXI_RESP_SLVERR);
    chk("oor_rdata", rd_data[0], 32'h0);
    wbuf[0] = 32'h00000BAD;
    aw_send(32'h0, 8'd0, AXI_BURST_WRAP, 4'h2);
    w_send(1, 4'hF, 1'b0);
    b_recv("wrap_err", AXI_RESP_SLVERR, 4'h2);
    ar_read(32'h0, 8'd0, AXI_BURST_INCR, 4'h2);
    chk("wrap_dropped", rd_data[0], 32'hCAFEF00D);
`else
    chk("oor_rresp", rd_resp[0], AXI_RESP_OKAY);
    chk("oor_rdata", rd_data[0], 32'hCAFEF00D);
`endif

    // Reset during beat 2 of a 4-beat write
    aw_send(32'h200, 8'd3, AXI_BURST_INCR, 4'h7);
    axi_if.wvalid = 1'b1; axi_if.wdata = 32'h11; axi_if.wstrb = 4'hF; axi_if.wlast = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = axi_if.wready;
      tick();
    end
    if (!done) chk("rstmid_w_timeout", 1, 0);
    axi_if.wdata = 32'h22;
    rstn = 1'b0;
    tick();
    tick();
    axi_if.wvalid = 1'b0;
    rstn = 1'b1;
    tick();
    chk("rstmid_awready", axi_if.awready, 1);
    chk("rstmid_wready",  axi_if.wready,  0);
    chk("rstmid_bvalid",  axi_if.bvalid,  0);
    wbuf[0] = 32'h5A5A5A5A;
    aw_send(32'h200, 8'd0, AXI_BURST_INCR, 4'h8);
    w_send(1, 4'hF, 1'b0);
    b_recv("rstmid_new", AXI_RESP_OKAY, 4'h8);
    ar_read(32'h200, 8'd0, AXI_BURST_INCR, 4'h8);
    chk("rstmid_new_rdata", rd_data[0], 32'h5A5A5A5A);
    ar_read(32'h10, 8'd0, AXI_BURST_INCR, 4'h8);
    chk("rstmid_retained", rd_data[0], 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
